// File: rtl/pixel_event_gen.sv
// -----------------------------------------------------------------------------
// pixel_event_gen
//   Synthetic pixel-event source for a ROWS x COLS event-camera array. It
//   drives per-pixel polarity requests (bit0 = OFF, bit1 = ON) and holds each
//   request until that pixel's grant arrives. It has three run modes:
//   LFSR-random with density control, raster sweep and full-array burst.
//   Saturating event and grant counters and a sticky error flag let BIST and
//   bring-up run without a host.
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   enable_i       run request; falling to 0 moves SCAN into DRAIN
//   mode_i         00 idle, 01 random, 10 raster, 11 burst (sampled in IDLE)
//   density_i      random mode injects when lfsr[7:0] < density_i
//   seed_i         LFSR seed
//   load_seed_i    load seed_i into the LFSR while IDLE (a zero seed becomes 1)
//   gnt_i          per-pixel grant, one bit per pixel
//   req_o          per-pixel polarity requests, POLARITY bits per pixel
//   busy_o         high in SCAN, BURST and DRAIN
//   pending_o      OR of all request bits
//   event_count_o  injected requests, saturating
//   grant_count_o  grants consumed on requesting pixels, saturating
//   err_o          sticky: a grant arrived on a pixel with no request
// -----------------------------------------------------------------------------
module pixel_event_gen #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int POLARITY = 2,
    parameter int CNT_W    = 16,
    parameter int LFSR_W   = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [1:0]                    mode_i,
    input  logic [7:0]                    density_i,
    input  logic [LFSR_W-1:0]             seed_i,
    input  logic                          load_seed_i,
    input  logic [ROWS*COLS-1:0]          gnt_i,
    output logic [ROWS*COLS*POLARITY-1:0] req_o,
    output logic                          busy_o,
    output logic                          pending_o,
    output logic [CNT_W-1:0]              event_count_o,
    output logic [CNT_W-1:0]              grant_count_o,
    output logic                          err_o
);

    localparam int NPIX  = ROWS * COLS;
    localparam int PTR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PC_W  = $clog2(NPIX + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    // Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form).
    localparam logic [LFSR_W-1:0]   TAPS     = LFSR_W'(32'h8020_0003);
    localparam logic [POLARITY-1:0] POL_OFF  = POLARITY'(1);
    localparam logic [POLARITY-1:0] POL_ON   = POLARITY'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic                           raster_on_q, raster_on_d;
    logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
    logic [NPIX*POLARITY-1:0]       req_q, req_d;
    logic [CNT_W-1:0]               event_cnt_q, event_cnt_d;
    logic [CNT_W-1:0]               grant_cnt_q, grant_cnt_d;
    logic                           err_q, err_d;

    logic                           scan_act;
    logic                           burst_act;
    logic                           scan_hit;
    logic                           inj_on;
    logic [LFSR_W-1:0]              lfsr_next;
    logic [NPIX-1:0]                pixel_idle;
    logic [NPIX-1:0]                inj_vec;
    logic [NPIX-1:0]                gnt_valid;
    logic [NPIX-1:0]                gnt_bad;
    logic [PC_W-1:0]                inj_cnt;
    logic [PC_W-1:0]                gnt_cnt;
    logic [SUM_W-1:0]               ev_sum;
    logic [SUM_W-1:0]               gn_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [NPIX-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NPIX; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

    // Random mode gates on the LFSR; raster injects at every idle pixel visited.
    assign scan_hit = (mode_q == 2'b01) ? (lfsr_q[7:0] < density_i) : 1'b1;
    // Raster polarity comes from the wrap toggle; random and burst use lfsr[8].
    assign inj_on   = (scan_act && mode_q != 2'b01) ? raster_on_q : lfsr_q[8];

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        raster_on_d = raster_on_q;
        lfsr_d      = lfsr_q;
        scan_act    = 1'b0;
        burst_act   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_seed_i) begin
                    lfsr_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
                end
                if (enable_i && mode_i != 2'b00) begin
                    // Each run starts from pixel (0,0) with OFF raster polarity.
                    mode_d      = mode_i;
                    ptr_d       = '0;
                    raster_on_d = 1'b0;
                    state_d     = (mode_i == 2'b11) ? ST_BURST : ST_SCAN;
                end
            end
            ST_SCAN: begin
                scan_act = 1'b1;
                lfsr_d   = lfsr_next;
                if (ptr_q == PTR_LAST) begin
                    ptr_d       = '0;
                    raster_on_d = ~raster_on_q;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
                if (!enable_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_BURST: begin
                burst_act = 1'b1;
                lfsr_d    = lfsr_next;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pending_o) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- per pixel
    // A grant on a requesting pixel clears it and blocks injection that
    // cycle; injection only ever targets an idle pixel, so a pixel never
    // holds both polarities.
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
        assign pixel_idle[gi] = ~|req_q[gi*POLARITY +: POLARITY];
        assign gnt_valid[gi]  = gnt_i[gi] & ~pixel_idle[gi];
        assign gnt_bad[gi]    = gnt_i[gi] & pixel_idle[gi];
        assign inj_vec[gi]    = pixel_idle[gi] & ~gnt_i[gi] &
                                (burst_act | (scan_act & scan_hit & (ptr_q == PTR_W'(gi))));
        assign req_d[gi*POLARITY +: POLARITY] =
            gnt_valid[gi] ? '0 :
            inj_vec[gi]   ? (inj_on ? POL_ON : POL_OFF) :
                            req_q[gi*POLARITY +: POLARITY];
    end

    // ----------------------------------------------------------- counters
    assign inj_cnt     = popcount(inj_vec);
    assign gnt_cnt     = popcount(gnt_valid);
    assign ev_sum      = SUM_W'(event_cnt_q) + SUM_W'(inj_cnt);
    assign gn_sum      = SUM_W'(grant_cnt_q) + SUM_W'(gnt_cnt);
    assign event_cnt_d = (ev_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ev_sum[CNT_W-1:0];
    assign grant_cnt_d = (gn_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : gn_sum[CNT_W-1:0];
    assign err_d       = err_q | (|gnt_bad);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            ptr_q       <= '0;
            raster_on_q <= 1'b0;
            lfsr_q      <= LFSR_W'(1);
            req_q       <= '0;
            event_cnt_q <= '0;
            grant_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            raster_on_q <= raster_on_d;
            lfsr_q      <= lfsr_d;
            req_q       <= req_d;
            event_cnt_q <= event_cnt_d;
            grant_cnt_q <= grant_cnt_d;
            err_q       <= err_d;
        end
    end

    assign req_o         = req_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign pending_o     = |req_q;
    assign event_count_o = event_cnt_q;
    assign grant_count_o = grant_cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_pixel_event_gen.sv
// Directed testbench for pixel_event_gen (16x16 array, 2 polarity bits).
module tb_pixel_event_gen;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int PW   = 2;
    localparam int NPIX = ROWS * COLS;
    localparam int W    = NPIX * PW;

    logic             clk;
    logic             reset_i;
    logic             enable_i;
    logic [1:0]       mode_i;
    logic [7:0]       density_i;
    logic [31:0]      seed_i;
    logic             load_seed_i;
    logic [NPIX-1:0]  gnt_i;
    logic [W-1:0]     req_o;
    logic             busy_o;
    logic             pending_o;
    logic [15:0]      event_count_o;
    logic [15:0]      grant_count_o;
    logic             err_o;

    int n_cmp = 0;
    int n_err = 0;

    pixel_event_gen #(
        .ROWS(ROWS), .COLS(COLS), .POLARITY(PW), .CNT_W(16), .LFSR_W(32)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .density_i    (density_i),
        .seed_i       (seed_i),
        .load_seed_i  (load_seed_i),
        .gnt_i        (gnt_i),
        .req_o        (req_o),
        .busy_o       (busy_o),
        .pending_o    (pending_o),
        .event_count_o(event_count_o),
        .grant_count_o(grant_count_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("[tb] %-16s ok obs=%0h", tag, obs);
        end else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("[tb] %-16s ok", tag);
        end else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        enable_i    = 1'b0;
        mode_i      = 2'b00;
        density_i   = 8'd0;
        seed_i      = 32'd0;
        load_seed_i = 1'b0;
        gnt_i       = '0;
        ticks(2);
        reset_i     = 1'b0;
    endtask

    // Reference Galois LFSR, x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    logic [W-1:0] exp_req;
    logic [31:0]  s;
    int           exp_ev;

    initial begin
        // ---------------- 1: reset state
        do_reset();
        chk("rst_req0", 64'(pending_o), 64'd0);
        chk_vec("rst_reqvec", req_o, '0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_evcnt", 64'(event_count_o), 64'd0);
        chk("rst_gncnt", 64'(grant_count_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        ticks(20);
        chk("idle20_busy", 64'(busy_o), 64'd0);
        chk("idle20_ev", 64'(event_count_o), 64'd0);

        // ---------------- 2: raster sweep, no grants
        mode_i   = 2'b10;
        enable_i = 1'b1;
        tick();                         // IDLE -> SCAN
        chk("ras_busy", 64'(busy_o), 64'd1);
        ticks(255);                     // 255 scan cycles done
        chk("ras_ev255", 64'(event_count_o), 64'd255);
        chk("ras_pix255_idle", 64'(req_o[W-1 -: 2]), 64'd0);
        chk("ras_pix254_off", 64'(req_o[W-3 -: 2]), 64'd1);
        tick();                         // 256th scan cycle
        for (int i = 0; i < NPIX; i++) exp_req[i*PW +: PW] = 2'b01;
        chk("ras_ev256", 64'(event_count_o), 64'd256);
        chk_vec("ras_all_off", req_o, exp_req);
        ticks(42);
        chk("ras_no_more_ev", 64'(event_count_o), 64'd256);
        chk_vec("ras_hold", req_o, exp_req);
        enable_i = 1'b0;
        ticks(3);
        chk("ras_drain_busy", 64'(busy_o), 64'd1);

        // ---------------- 3: burst with seed 1, one grant per cycle
        do_reset();
        mode_i      = 2'b11;
        seed_i      = 32'h1;
        load_seed_i = 1'b1;
        tick();
        load_seed_i = 1'b0;
        enable_i    = 1'b1;
        tick();                         // IDLE -> BURST
        enable_i    = 1'b0;
        chk("bst_busy", 64'(busy_o), 64'd1);
        chk("bst_pre_pend", 64'(pending_o), 64'd0);
        tick();                         // burst injection lands
        chk("bst_ev256", 64'(event_count_o), 64'd256);
        chk_vec("bst_all_off", req_o, exp_req);
        for (int k = 0; k < NPIX; k++) begin
            gnt_i    = '0;
            gnt_i[k] = 1'b1;
            tick();
            if (k == 127) begin
                chk("bst_gn128", 64'(grant_count_o), 64'd128);
                chk("bst_pend_mid", 64'(pending_o), 64'd1);
            end
        end
        gnt_i = '0;
        chk("bst_gn256", 64'(grant_count_o), 64'd256);
        chk("bst_pend_done", 64'(pending_o), 64'd0);
        chk("bst_still_drain", 64'(busy_o), 64'd1);
        tick();
        chk("bst_idle", 64'(busy_o), 64'd0);
        chk("bst_err", 64'(err_o), 64'd0);
        chk("bst_ev_final", 64'(event_count_o), 64'd256);

        // ---------------- 4: random mode, density 0 then 255
        do_reset();
        mode_i      = 2'b01;
        density_i   = 8'd0;
        seed_i      = 32'hACE1_2345;
        load_seed_i = 1'b1;
        tick();
        load_seed_i = 1'b0;
        enable_i    = 1'b1;
        tick();
        ticks(512);
        chk("rnd_d0_ev", 64'(event_count_o), 64'd0);
        chk("rnd_d0_pend", 64'(pending_o), 64'd0);
        enable_i = 1'b0;
        ticks(2);
        chk("rnd_d0_idle", 64'(busy_o), 64'd0);
        density_i   = 8'd255;
        load_seed_i = 1'b1;
        tick();
        load_seed_i = 1'b0;
        enable_i    = 1'b1;
        tick();                         // IDLE -> SCAN
        ticks(255);
        enable_i = 1'b0;
        tick();                         // 256th scan cycle, then DRAIN
        s       = 32'hACE1_2345;
        exp_ev  = 0;
        exp_req = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (s[7:0] < 8'd255) begin
                exp_req[i*PW +: PW] = s[8] ? 2'b10 : 2'b01;
                exp_ev++;
            end
            s = lfsr_step(s);
        end
        chk("rnd_d255_ev", 64'(event_count_o), 64'(exp_ev));
        chk_vec("rnd_d255_req", req_o, exp_req);

        // ---------------- 5: grant on idle pixel (3,5)
        do_reset();
        gnt_i[3*COLS+5] = 1'b1;
        tick();
        gnt_i = '0;
        chk("bad_gnt_err", 64'(err_o), 64'd1);
        chk("bad_gnt_cnt", 64'(grant_count_o), 64'd0);
        ticks(5);
        chk("bad_gnt_sticky", 64'(err_o), 64'd1);

        // ---------------- 6: async reset mid-SCAN
        do_reset();
        chk("rst_clr_err", 64'(err_o), 64'd0);
        mode_i   = 2'b10;
        enable_i = 1'b1;
        tick();
        ticks(40);
        chk("mid_ev40", 64'(event_count_o), 64'd40);
        chk("mid_pend", 64'(pending_o), 64'd1);
        #3;                             // well away from any clock edge
        reset_i = 1'b1;
        #1;
        chk_vec("async_req0", req_o, '0);
        chk("async_busy0", 64'(busy_o), 64'd0);
        chk("async_ev0", 64'(event_count_o), 64'd0);
        tick();
        reset_i = 1'b0;
        tick();                         // IDLE -> SCAN
        tick();                         // first scan cycle hits pixel (0,0)
        exp_req = '0;
        exp_req[1:0] = 2'b01;
        chk_vec("restart_ptr0", req_o, exp_req);
        chk("restart_ev1", 64'(event_count_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
